membus_arbiter: RTL and testbench

//   Parametrised memory-bus arbiter: NUM_CH bus masters (ch0 = host register-bus

---
 rtl/membus_arbiter.sv | 132 +++++++++++++
 tb/tb_membus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// membus_arbiter: NUM_CH masters share one memory port. Ch0 has fixed priority
// bounded by a burst guard; ch1..NUM_CH-1 are served round-robin.
// Ports: clk/rst (async, active-high); ch_* flattened per-channel request side
// (strobe, addr, write, wrdata, bytesel in; grant comb, ack reg, rdvalid out,
// rddata broadcast); mem_* single memory port (one access per clk, read data
// returns RD_LATENCY clks after issue).
module membus_arbiter #(
   parameter  int NUM_CH        = 3,
   parameter  int ADDR_W        = 18,
   parameter  int DATA_W        = 32,
   parameter  int RD_LATENCY    = 1,
   parameter  int MAX_CH0_BURST = 4,
   localparam int BE_W          = DATA_W / 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_strobe,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*DATA_W-1:0] ch_wrdata,
   input  logic [NUM_CH*BE_W-1:0]   ch_bytesel,
   output logic [NUM_CH-1:0]        ch_grant,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [NUM_CH-1:0]        ch_rdvalid,
   output logic [DATA_W-1:0]        ch_rddata,
   output logic                     mem_strobe,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     mem_write,
   output logic [DATA_W-1:0]        mem_wrdata,
   output logic [BE_W-1:0]          mem_bytesel,
   input  logic [DATA_W-1:0]        mem_rddata
);

   localparam int PTR_W   = $clog2(NUM_CH);
   // With the guard off the counter is never compared, so one bit suffices.
   localparam int CNT_MAX = (MAX_CH0_BURST == 0) ? 1 : MAX_CH0_BURST;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]                   ch0_cnt_q, ch0_cnt_d;
   logic [NUM_CH-1:0]                  ack_q;
   logic [RD_LATENCY-1:0][NUM_CH-1:0]  rd_pipe_q, rd_pipe_d;

   logic              rr_hit;
   logic [PTR_W-1:0]  rr_idx;
   logic [PTR_W-1:0]  rr_sel;
   logic              others_req;
   logic              ch0_mask;
   logic              ch0_win;
   logic [NUM_CH-1:0] rd_issue;

   // Scan ch1..NUM_CH-1 starting just after the last round-robin winner.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = '0;
      rr_sel = '0;
      for (int k = 1; k < NUM_CH; k++) begin
         rr_sel = PTR_W'((int'(rr_ptr_q) - 1 + k) % (NUM_CH - 1) + 1);
         if (!rr_hit && ch_strobe[rr_sel]) begin
            rr_hit = 1'b1;
            rr_idx = rr_sel;
         end
      end
   end

   assign others_req = |ch_strobe[NUM_CH-1:1];
   // Ch0 yields for one clk once it has taken MAX_CH0_BURST grants in a row.
   assign ch0_mask   = (MAX_CH0_BURST != 0) &&
                       (ch0_cnt_q == CNT_W'(CNT_MAX)) && others_req;
   assign ch0_win    = ch_strobe[0] && !ch0_mask;

   always_comb begin
      ch_grant = '0;
      if (ch0_win)     ch_grant[0]      = 1'b1;
      else if (rr_hit) ch_grant[rr_idx] = 1'b1;
   end

   always_comb begin
      mem_addr    = '0;
      mem_write   = 1'b0;
      mem_wrdata  = '0;
      mem_bytesel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_grant[i]) begin
            mem_addr    = ch_addr[i*ADDR_W +: ADDR_W];
            mem_write   = ch_write[i];
            mem_wrdata  = ch_wrdata[i*DATA_W +: DATA_W];
            mem_bytesel = ch_bytesel[i*BE_W +: BE_W];
         end
      end
   end

   assign mem_strobe = |ch_grant;
   assign rd_issue   = ch_grant & ~ch_write;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (!ch0_win && rr_hit) rr_ptr_d = rr_idx;
      ch0_cnt_d = '0;
      if (ch0_win) begin
         ch0_cnt_d = (ch0_cnt_q == CNT_W'(CNT_MAX)) ? ch0_cnt_q
                                                    : ch0_cnt_q + 1'b1;
      end
   end

   always_comb begin
      rd_pipe_d    = rd_pipe_q;
      rd_pipe_d[0] = rd_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
         rd_pipe_d[i] = rd_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q  <= PTR_W'(NUM_CH - 1);
         ch0_cnt_q <= '0;
         ack_q     <= '0;
         rd_pipe_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         ch0_cnt_q <= ch0_cnt_d;
         ack_q     <= ch_grant;
         rd_pipe_q <= rd_pipe_d;
      end
   end

   assign ch_ack     = ack_q;
   assign ch_rdvalid = rd_pipe_q[RD_LATENCY-1];
   assign ch_rddata  = mem_rddata;

endmodule

// File: tb/tb_membus_arbiter.sv
// tb_membus_arbiter: scoreboard bench for membus_arbiter; two instances share
// stimulus, one with RD_LATENCY=1 and one with RD_LATENCY=3.
module tb_membus_arbiter;

   localparam int NCH = 3;
   localparam int AW  = 18;
   localparam int DW  = 32;
   localparam int BW  = 4;

   typedef struct {
      int ch;
      int due;
   } rd_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NCH-1:0]  ch_strobe = '0;
   logic [NCH-1:0]  ch_write = '0;
   logic [NCH*AW-1:0] ch_addr = '0;
   logic [NCH*DW-1:0] ch_wrdata = '0;
   logic [NCH*BW-1:0] ch_bytesel = '0;
   logic [DW-1:0]   mem_rddata;

   logic [NCH-1:0]  g1, a1, rv1;
   logic [DW-1:0]   rd1;
   logic            ms1, mw1;
   logic [AW-1:0]   ma1;
   logic [DW-1:0]   mwd1;
   logic [BW-1:0]   mbs1;

   logic [NCH-1:0]  g3, a3, rv3;
   logic [DW-1:0]   rd3;
   logic            ms3, mw3;
   logic [AW-1:0]   ma3;
   logic [DW-1:0]   mwd3;
   logic [BW-1:0]   mbs3;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   rd_t sb1[$];
   rd_t sb3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign mem_rddata = {16'hC0DE, cyc[15:0]};

   membus_arbiter #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
      .RD_LATENCY(1), .MAX_CH0_BURST(4)
   ) dut1 (
      .clk(clk), .rst(rst),
      .ch_strobe(ch_strobe), .ch_addr(ch_addr), .ch_write(ch_write),
      .ch_wrdata(ch_wrdata), .ch_bytesel(ch_bytesel),
      .ch_grant(g1), .ch_ack(a1), .ch_rdvalid(rv1), .ch_rddata(rd1),
      .mem_strobe(ms1), .mem_addr(ma1), .mem_write(mw1),
      .mem_wrdata(mwd1), .mem_bytesel(mbs1), .mem_rddata(mem_rddata)
   );

   membus_arbiter #(
      .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW),
      .RD_LATENCY(3), .MAX_CH0_BURST(4)
   ) dut3 (
      .clk(clk), .rst(rst),
      .ch_strobe(ch_strobe), .ch_addr(ch_addr), .ch_write(ch_write),
      .ch_wrdata(ch_wrdata), .ch_bytesel(ch_bytesel),
      .ch_grant(g3), .ch_ack(a3), .ch_rdvalid(rv3), .ch_rddata(rd3),
      .mem_strobe(ms3), .mem_addr(ma3), .mem_write(mw3),
      .mem_wrdata(mwd3), .mem_bytesel(mbs3), .mem_rddata(mem_rddata)
   );

   task automatic set_ch(input int c, input logic s, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] b);
      ch_strobe[c]          = s;
      ch_write[c]           = w;
      ch_addr[c*AW +: AW]   = a;
      ch_wrdata[c*DW +: DW] = d;
      ch_bytesel[c*BW +: BW] = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      ch_strobe = '0;
      ch_write  = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb1.delete();
      sb3.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      n_chk++;
      if (a1 !== '0 || a3 !== '0) begin
         n_fail++;
         $display("FAIL reset_ack: got %b/%b want 000", a1, a3);
      end
      n_chk++;
      if (rv1 !== '0 || rv3 !== '0) begin
         n_fail++;
         $display("FAIL reset_rdvalid: got %b/%b want 000", rv1, rv3);
      end
      n_chk++;
      if (g1 !== '0 || ms1 !== 1'b0 || ma1 !== '0 || mw1 !== 1'b0
          || mbs1 !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: grant %b strobe %b addr %h wr %b be %b want 0",
                  g1, ms1, ma1, mw1, mbs1);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ch0_stream();
      logic [NCH-1:0] prev;
      logic [NCH-1:0] exp_rv;
      prev = '0;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         if (k < 6) set_ch(0, 1'b1, 1'b0, AW'(18'h100 + k), '0, 4'hF);
         else       ch_strobe = '0;
         #1;
         exp_rv = '0;
         if (sb1.size() > 0 && sb1[0].due == cyc) begin
            exp_rv[sb1[0].ch] = 1'b1;
            void'(sb1.pop_front());
         end
         n_chk++;
         if (rv1 !== exp_rv) begin
            n_fail++;
            $display("FAIL ch0_rdvalid k=%0d: got %b want %b", k, rv1, exp_rv);
         end
         n_chk++;
         if (a1 !== prev) begin
            n_fail++;
            $display("FAIL ch0_ack k=%0d: got %b want %b", k, a1, prev);
         end
         if (k < 6) begin
            n_chk++;
            if (g1 !== 3'b001 || ma1 !== AW'(18'h100 + k) || ms1 !== 1'b1) begin
               n_fail++;
               $display("FAIL ch0_grant k=%0d: got g=%b addr=%h want 001 %h",
                        k, g1, ma1, AW'(18'h100 + k));
            end
            sb1.push_back('{0, cyc + 1});
            prev = 3'b001;
         end else begin
            n_chk++;
            if (ms1 !== 1'b0 || ma1 !== '0 || mw1 !== 1'b0 || mbs1 !== '0) begin
               n_fail++;
               $display("FAIL idle_mem k=%0d: strobe %b addr %h wr %b be %b want 0",
                        k, ms1, ma1, mw1, mbs1);
            end
            prev = '0;
         end
         @(negedge clk);
      end
      n_chk++;
      if (sb1.size() != 0) begin
         n_fail++;
         $display("FAIL ch0_drain: %0d reads pending want 0", sb1.size());
      end
   endtask

   task automatic test_rr();
      logic [NCH-1:0] exp_g;
      logic [NCH-1:0] exp_rv;
      do_reset();
      set_ch(1, 1'b1, 1'b0, 18'h00200, '0, 4'hF);
      set_ch(2, 1'b1, 1'b0, 18'h00300, '0, 4'hF);
      for (int k = 0; k < 8; k++) begin
         if (k == 6) ch_strobe = '0;
         #1;
         exp_rv = '0;
         if (sb1.size() > 0 && sb1[0].due == cyc) begin
            exp_rv[sb1[0].ch] = 1'b1;
            void'(sb1.pop_front());
         end
         n_chk++;
         if (rv1 !== exp_rv || (exp_rv != '0 && rd1 !== mem_rddata)) begin
            n_fail++;
            $display("FAIL rr_rdvalid k=%0d: got %b want %b", k, rv1, exp_rv);
         end
         if (k < 6) begin
            exp_g = (k % 2 == 0) ? 3'b010 : 3'b100;
            n_chk++;
            if (g1 !== exp_g ||
                ma1 !== ((k % 2 == 0) ? 18'h00200 : 18'h00300)) begin
               n_fail++;
               $display("FAIL rr_grant k=%0d: got %b addr %h want %b",
                        k, g1, ma1, exp_g);
            end
            sb1.push_back('{(k % 2 == 0) ? 1 : 2, cyc + 1});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_burst();
      int pat[10];
      logic [NCH-1:0] exp_g;
      logic [NCH-1:0] prev;
      pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
      prev = '0;
      do_reset();
      set_ch(0, 1'b1, 1'b0, 18'h00010, '0, 4'hF);
      set_ch(1, 1'b1, 1'b0, 18'h00020, '0, 4'hF);
      set_ch(2, 1'b1, 1'b0, 18'h00030, '0, 4'hF);
      for (int k = 0; k < 20; k++) begin
         #1;
         exp_g = '0;
         exp_g[pat[k % 10]] = 1'b1;
         n_chk++;
         if (g1 !== exp_g || g3 !== exp_g) begin
            n_fail++;
            $display("FAIL burst_grant k=%0d: got %b/%b want %b",
                     k, g1, g3, exp_g);
         end
         n_chk++;
         if (a1 !== prev) begin
            n_fail++;
            $display("FAIL burst_ack k=%0d: got %b want %b", k, a1, prev);
         end
         prev = exp_g;
         @(negedge clk);
      end
      ch_strobe = '0;
   endtask

   task automatic test_write();
      do_reset();
      set_ch(0, 1'b1, 1'b1, 18'h000A5, 32'h5A5A5A5A, 4'b0010);
      #1;
      n_chk++;
      if (g1 !== 3'b001 || ms1 !== 1'b1 || mw1 !== 1'b1 || ma1 !== 18'h000A5
          || mwd1 !== 32'h5A5A5A5A || mbs1 !== 4'b0010) begin
         n_fail++;
         $display("FAIL wr_issue: g %b s %b w %b a %h d %h be %b want 001 1 1 000a5 5a5a5a5a 0010",
                  g1, ms1, mw1, ma1, mwd1, mbs1);
      end
      @(negedge clk);
      ch_strobe = '0;
      ch_write  = '0;
      #1;
      n_chk++;
      if (a1 !== 3'b001) begin
         n_fail++;
         $display("FAIL wr_ack: got %b want 001", a1);
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (rv1 !== '0 || rv3 !== '0) begin
            n_fail++;
            $display("FAIL wr_rdvalid k=%0d: got %b/%b want 000", k, rv1, rv3);
         end
         @(negedge clk);
         #1;
      end
      @(negedge clk);
   endtask

   task automatic test_latency();
      logic [NCH-1:0] exp_g;
      logic [NCH-1:0] exp_rv;
      do_reset();
      set_ch(1, 1'b0, 1'b0, 18'h00111, '0, 4'hF);
      set_ch(2, 1'b0, 1'b0, 18'h00222, '0, 4'hF);
      for (int k = 0; k < 7; k++) begin
         ch_strobe = (k == 0) ? 3'b010 : (k == 1) ? 3'b100 : 3'b000;
         exp_g = ch_strobe;
         #1;
         exp_rv = '0;
         if (sb3.size() > 0 && sb3[0].due == cyc) begin
            exp_rv[sb3[0].ch] = 1'b1;
            void'(sb3.pop_front());
         end
         n_chk++;
         if (rv3 !== exp_rv || (exp_rv != '0 && rd3 !== mem_rddata)) begin
            n_fail++;
            $display("FAIL lat3_rdvalid k=%0d: got %b want %b", k, rv3, exp_rv);
         end
         n_chk++;
         if (g3 !== exp_g) begin
            n_fail++;
            $display("FAIL lat3_grant k=%0d: got %b want %b", k, g3, exp_g);
         end
         if (k == 0) sb3.push_back('{1, cyc + 3});
         if (k == 1) sb3.push_back('{2, cyc + 3});
         @(negedge clk);
      end
      n_chk++;
      if (sb3.size() != 0) begin
         n_fail++;
         $display("FAIL lat3_drain: %0d reads pending want 0", sb3.size());
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      set_ch(1, 1'b1, 1'b0, 18'h00333, '0, 4'hF);
      set_ch(2, 1'b0, 1'b0, 18'h00444, '0, 4'hF);
      #1;
      n_chk++;
      if (g3 !== 3'b010) begin
         n_fail++;
         $display("FAIL rst_pre_grant: got %b want 010", g3);
      end
      @(negedge clk);
      ch_strobe = '0;
      rst = 1'b1;
      #1;
      n_chk++;
      if (rv1 !== '0 || rv3 !== '0 || a1 !== '0) begin
         n_fail++;
         $display("FAIL rst_async: rdv %b/%b ack %b want 0", rv1, rv3, a1);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_chk++;
         if (rv3 !== '0 || rv1 !== '0) begin
            n_fail++;
            $display("FAIL rst_dropped k=%0d: got %b/%b want 000", k, rv1, rv3);
         end
         @(negedge clk);
      end
      ch_strobe = 3'b110;
      #1;
      n_chk++;
      if (g1 !== 3'b010 || g3 !== 3'b010) begin
         n_fail++;
         $display("FAIL rst_rr_restart: got %b/%b want 010", g1, g3);
      end
      @(negedge clk);
      ch_strobe = '0;
   endtask

   initial begin
      test_reset();
      test_ch0_stream();
      test_rr();
      test_burst();
      test_write();
      test_latency();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
